// File: rtl/counter_pkg.sv
// counter_pkg: direction/mode encodings and default width shared by the cascade counter.
package counter_pkg;
    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DOWN = 1'b0;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT = 1'b1;
    localparam int DEFAULT_WIDTH = 4;
endpackage

// File: rtl/updown_counter_cell.sv
// updown_counter_cell: loadable up/down counter with wrap or saturate behaviour.
module updown_counter_cell
    import counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             step,
    input  logic             dir,
    input  logic             mode_sat,
    output logic [WIDTH-1:0] count,
    output logic             moved,
    output logic             term
);
    logic [WIDTH-1:0] count_q, count_d, next_val;
    always_comb begin
        term = (dir == DIR_UP) ? &count_q : (count_q == '0);
        // a saturated counter sitting at its terminal value does not count as a step
        moved = step && !(mode_sat == MODE_SAT && term);
        next_val = (dir == DIR_UP) ? count_q + 1'b1 : count_q - 1'b1;
        count_d = load ? load_val : moved ? next_val : count_q;
    end
    always_ff @(posedge clk) begin
        if (rst) count_q <= RST_VAL;
        else count_q <= count_d;
    end
    assign count = count_q;
endmodule

// File: rtl/cascade_updown_counter.sv
// cascade_updown_counter: counter B steps on the same edge that counter A steps onto match_a.
module cascade_updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_a,
    input  logic [WIDTH-1:0] load_b,
    input  logic             dir_a,
    input  logic             dir_b,
    input  logic             mode_sat,
    input  logic [WIDTH-1:0] match_a,
    output logic [WIDTH-1:0] count_a,
    output logic [WIDTH-1:0] count_b,
    output logic             tick_a,
    output logic             tc_b
);
    logic moved_a, term_a, moved_b, hit, tick_a_q, tick_a_d;
    logic [WIDTH-1:0] next_a;
    updown_counter_cell #(.WIDTH(WIDTH), .RST_VAL('0)) u_a (
        .clk(clk), .rst(rst), .load(load), .load_val(load_a), .step(en && !load),
        .dir(dir_a), .mode_sat(mode_sat), .count(count_a), .moved(moved_a), .term(term_a)
    );
    updown_counter_cell #(.WIDTH(WIDTH), .RST_VAL({WIDTH{1'b1}})) u_b (
        .clk(clk), .rst(rst), .load(load), .load_val(load_b), .step(hit),
        .dir(dir_b), .mode_sat(mode_sat), .count(count_b), .moved(moved_b), .term(tc_b)
    );
    // compare against A's next value so B moves on the same edge A arrives
    always_comb begin
        next_a = (dir_a == DIR_UP) ? count_a + 1'b1 : count_a - 1'b1;
        hit = en && !load && moved_a && (next_a == match_a);
        tick_a_d = hit;
    end
    always_ff @(posedge clk) begin
        if (rst) tick_a_q <= 1'b0;
        else tick_a_q <= tick_a_d;
    end
    assign tick_a = tick_a_q;
    logic unused;
    assign unused = term_a ^ moved_b;
endmodule

// File: tb/tb_cascade_updown_counter.sv
// tb_cascade_updown_counter: directed and random checks against an arithmetic reference model.
module tb_cascade_updown_counter;
    localparam int W = 4;
    localparam int MAX = (1 << W) - 1;
    logic clk = 0, rst = 0, en = 0, load = 0, dir_a = 1, dir_b = 0, mode_sat = 0;
    logic [W-1:0] load_a = 0, load_b = 0, match_a = 0;
    logic [W-1:0] count_a, count_b;
    logic tick_a, tc_b;
    int tests = 0, fails = 0;
    int ma = 0, mb = MAX, mt = 0;

    cascade_updown_counter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_a(load_a), .load_b(load_b),
        .dir_a(dir_a), .dir_b(dir_b), .mode_sat(mode_sat), .match_a(match_a),
        .count_a(count_a), .count_b(count_b), .tick_a(tick_a), .tc_b(tc_b)
    );

    always #5 clk = ~clk;

    function automatic int advance(int v, bit up, bit sat);
        int r = up ? v + 1 : v - 1;
        if (r > MAX || r < 0) return sat ? v : (r + MAX + 1) % (MAX + 1);
        return r;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(string tag);
        int na;
        if (rst) begin
            ma = 0; mb = MAX; mt = 0;
        end else if (load) begin
            ma = load_a; mb = load_b; mt = 0;
        end else if (!en) begin
            mt = 0;
        end else begin
            na = advance(ma, dir_a, mode_sat);
            mt = (na != ma && na == match_a) ? 1 : 0;
            ma = na;
            if (mt == 1) mb = advance(mb, dir_b, mode_sat);
        end
        @(posedge clk);
        #1;
        chk({tag, ".count_a"}, 32'(count_a), 32'(ma));
        chk({tag, ".count_b"}, 32'(count_b), 32'(mb));
        chk({tag, ".tick_a"}, 32'(tick_a), 32'(mt));
        chk({tag, ".tc_b"}, 32'(tc_b), 32'((dir_b ? mb == MAX : mb == 0) ? 1 : 0));
    endtask

    initial begin
        rst = 1; cyc("reset"); rst = 0;
        chk("reset.tc_b_eq_dir_b", 32'(tc_b), 32'(dir_b));
        en = 1; dir_a = 1; dir_b = 0; match_a = 12; mode_sat = 0;
        for (int i = 1; i <= 12; i++) cyc("wrap_up");
        chk("wrap_up.e12_a", 32'(count_a), 12);
        chk("wrap_up.e12_b", 32'(count_b), 14);
        chk("wrap_up.e12_tick", 32'(tick_a), 1);
        cyc("wrap_up");
        chk("wrap_up.e13_tick", 32'(tick_a), 0);
        for (int i = 14; i <= 28; i++) cyc("wrap_up");
        chk("wrap_up.e28_a", 32'(count_a), 12);
        chk("wrap_up.e28_b", 32'(count_b), 13);

        rst = 1; cyc("reset2"); rst = 0;
        mode_sat = 1; match_a = 15; dir_a = 1;
        for (int i = 1; i <= 15; i++) cyc("sat_a");
        chk("sat_a.e15_b", 32'(count_b), 14);
        chk("sat_a.e15_tick", 32'(tick_a), 1);
        for (int i = 0; i < 10; i++) cyc("sat_a_hold");
        chk("sat_a.hold_a", 32'(count_a), 15);
        chk("sat_a.hold_b", 32'(count_b), 14);

        load = 1; load_a = 3; load_b = 0; en = 1; cyc("load");
        chk("load.a", 32'(count_a), 3);
        load = 0; match_a = 4; dir_b = 0; mode_sat = 0; cyc("b_wrap");
        chk("b_wrap.a", 32'(count_a), 4);
        chk("b_wrap.b", 32'(count_b), 15);

        load = 1; load_a = 0; load_b = 0; cyc("sat_b_load");
        load = 0; mode_sat = 1; dir_b = 0; match_a = 5; dir_a = 1;
        for (int i = 0; i < 20; i++) cyc("sat_b");
        chk("sat_b.b", 32'(count_b), 0);
        chk("sat_b.tc_b", 32'(tc_b), 1);

        load = 1; load_a = 0; load_b = 7; cyc("down_load");
        load = 0; dir_a = 0; mode_sat = 0; match_a = 15; cyc("down_wrap");
        chk("down_wrap.a", 32'(count_a), 15);
        chk("down_wrap.b", 32'(count_b), 6);
        chk("down_wrap.tick", 32'(tick_a), 1);

        load = 1; load_a = 5; load_b = 3; cyc("rst_mid_load");
        load = 0; dir_a = 1; match_a = 6;
        rst = 1; load = 1; en = 1; cyc("rst_mid");
        chk("rst_mid.a", 32'(count_a), 0);
        chk("rst_mid.b", 32'(count_b), 15);
        chk("rst_mid.tick", 32'(tick_a), 0);
        rst = 0; load = 0; en = 0; cyc("rst_mid_after");

        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            load = ($urandom_range(0, 19) == 0);
            en = ($urandom_range(0, 7) != 0);
            dir_a = ($urandom_range(0, 9) != 0) ? dir_a : ~dir_a;
            dir_b = $urandom_range(0, 1) != 0;
            mode_sat = ($urandom_range(0, 29) == 0) ? ~mode_sat : mode_sat;
            match_a = ($urandom_range(0, 3) == 0) ? W'($urandom) : match_a;
            load_a = W'($urandom);
            load_b = W'($urandom);
            cyc("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
